// File: rtl/regfile_wb_arbiter.sv
// Write-side arbiter for the 32x32 register file: merges the ALU writeback (port A)
// with FIFO-buffered long-latency results (port B) and tracks pending destinations.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_W-1:0]    a_rd,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_W-1:0]    b_rd,
    input  logic [DATA_W-1:0]    b_data,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_rd,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 WE3,
    output logic [ADDR_W-1:0]    A3,
    output logic [DATA_W-1:0]    WD3
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_A,
        GNT_FIFO,
        GNT_BYPASS
    } gnt_e;

    gnt_e                gnt;
    logic [ADDR_W-1:0]   rd_mem   [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [PTR_W-1:0]    wptr, rptr;
    logic [PTR_W:0]      count;
    logic [CNT_W-1:0]    starve_cnt;
    logic                empty, full, force_b, enq, deq;
    logic [ADDR_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_b, win;
    logic                we3_from_b;
    logic [2**ADDR_W-1:0] busy_nxt;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign force_b = !empty && (starve_cnt >= CNT_W'(STARVE_LIMIT));
    assign a_ready = !force_b;
    assign b_ready = !full;

    always_comb begin
        gnt      = GNT_IDLE;
        sel_rd   = '0;
        sel_data = '0;
        sel_b    = 1'b0;
        if (force_b)       gnt = GNT_FIFO;
        else if (a_valid)  gnt = GNT_A;
        else if (!empty)   gnt = GNT_FIFO;
        else if (b_valid)  gnt = GNT_BYPASS;
        case (gnt)
            GNT_A: begin
                sel_rd   = a_rd;
                sel_data = a_data;
            end
            GNT_FIFO: begin
                sel_rd   = rd_mem[rptr];
                sel_data = data_mem[rptr];
                sel_b    = 1'b1;
            end
            GNT_BYPASS: begin
                sel_rd   = b_rd;
                sel_data = b_data;
                sel_b    = 1'b1;
            end
            default: ;
        endcase
    end

    // A bypassed port-B request is consumed directly and never occupies a slot.
    assign enq = b_valid && !full && (gnt != GNT_BYPASS);
    assign deq = (gnt == GNT_FIFO);
    assign win = (gnt != GNT_IDLE) && (sel_rd != '0);

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[wptr]   <= b_rd;
            data_mem[wptr] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (enq) wptr <= wptr + PTR_W'(1);
            if (deq) rptr <= rptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
            if (deq || empty)
                starve_cnt <= '0;
            else if (gnt == GNT_A && starve_cnt < CNT_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE3        <= 1'b0;
            A3         <= '0;
            WD3        <= '0;
            we3_from_b <= 1'b0;
        end else begin
            WE3        <= win;
            we3_from_b <= win && sel_b;
            if (win) begin
                A3  <= sel_rd;
                WD3 <= sel_data;
            end
        end
    end

    // Clear lands on the edge the register file captures; a same-edge issue re-sets it.
    always_comb begin
        busy_nxt = busy;
        if (WE3 && we3_from_b)
            busy_nxt[A3] = 1'b0;
        if (iss_valid && iss_rd != '0)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-computed expectations for writeback
// latency, arbitration, starvation forcing, FIFO order, r0 handling and the scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    regfile_wb_arbiter #(
        .DATA_W(32),
        .ADDR_W(5),
        .DEPTH(4),
        .STARVE_LIMIT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .busy(busy),
        .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
        check({tag, ".WE3"}, {31'd0, WE3}, 32'd1);
        check({tag, ".A3"}, {27'd0, A3}, {27'd0, rd});
        check({tag, ".WD3"}, WD3, d);
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0; iss_valid = 1'b0; iss_rd = '0;
        tick(); tick();
        check("rst.WE3", {31'd0, WE3}, 32'd0);
        check("rst.A3", {27'd0, A3}, 32'd0);
        check("rst.WD3", WD3, 32'd0);
        check("rst.busy", busy, 32'd0);
        check("rst.b_ready", {31'd0, b_ready}, 32'd1);
        check("rst.a_ready", {31'd0, a_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // single port-A write
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        check("a1.a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        check_wr("a1", 5'd5, 32'hDEADBEEF);
        tick();
        check("a1.idle_WE3", {31'd0, WE3}, 32'd0);
        check("a1.hold_WD3", WD3, 32'hDEADBEEF);

        // scoreboard set, then clear by a bypassed port-B write
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        check("sb.set9", busy, 32'h0000_0200);
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h1234;
        check("sb.b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        check_wr("sb.b9", 5'd9, 32'h1234);
        check("sb.still_busy", busy, 32'h0000_0200);
        tick();
        check("sb.clear9", busy, 32'd0);
        check("sb.idle", {31'd0, WE3}, 32'd0);

        // starvation: A held high, one B entry queued behind it
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA0;
        b_valid = 1'b1; b_rd = 5'd3; b_data = 32'hB0;
        tick();
        b_valid = 1'b0;
        check_wr("st.e0", 5'd1, 32'hA0);
        a_data = 32'hA1;
        tick();
        check_wr("st.e1", 5'd1, 32'hA1);
        check("st.e1.a_ready", {31'd0, a_ready}, 32'd1);
        a_data = 32'hA2;
        tick();
        check_wr("st.e2", 5'd1, 32'hA2);
        check("st.e2.a_ready", {31'd0, a_ready}, 32'd1);
        a_data = 32'hA3;
        tick();
        check_wr("st.e3", 5'd1, 32'hA3);
        check("st.e3.a_ready", {31'd0, a_ready}, 32'd0);
        a_data = 32'hA4;
        tick();
        check_wr("st.forced", 5'd3, 32'hB0);
        check("st.a_ready_back", {31'd0, a_ready}, 32'd1);
        tick();
        check_wr("st.a4", 5'd1, 32'hA4);
        a_valid = 1'b0;
        tick();
        check("st.idle", {31'd0, WE3}, 32'd0);

        // FIFO full: four B entries pushed behind A, a fifth held off
        a_valid = 1'b1; a_rd = 5'd2;
        for (int i = 0; i < 4; i++) begin
            a_data = 32'hC0 + 32'(i);
            b_valid = 1'b1; b_rd = 5'(10 + i); b_data = 32'hE1 + 32'(i);
            tick();
            check_wr("full.a", 5'd2, 32'hC0 + 32'(i));
        end
        b_rd = 5'd20; b_data = 32'hE5;
        check("full.b_ready", {31'd0, b_ready}, 32'd0);
        check("full.a_ready", {31'd0, a_ready}, 32'd0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check_wr("full.d1", 5'd10, 32'hE1);
        check("full.b_ready_back", {31'd0, b_ready}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_wr("full.drain", 5'(10 + i), 32'hE1 + 32'(i));
        end
        tick();
        check("full.no5th", {31'd0, WE3}, 32'd0);

        // r0 write is accepted but suppressed
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h55;
        check("r0.a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        check("r0.WE3", {31'd0, WE3}, 32'd0);

        // same-edge set and clear of r7: set wins
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        check("col.set7", busy, 32'h0000_0080);
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
        tick();
        b_valid = 1'b0;
        check_wr("col.b7", 5'd7, 32'h77);
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        check("col.set_wins", busy, 32'h0000_0080);
        // port-A write to a busy register leaves it busy
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h99;
        tick();
        a_valid = 1'b0;
        check_wr("col.a7", 5'd7, 32'h99);
        tick();
        check("col.a_no_clear", busy, 32'h0000_0080);
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h78;
        tick();
        b_valid = 1'b0;
        tick();
        check("col.cleared", busy, 32'd0);

        // reset mid-stream with three queued entries and busy = 0x104
        a_valid = 1'b1; a_rd = 5'd4; a_data = 32'hF0;
        b_valid = 1'b1; b_rd = 5'd20; b_data = 32'hD0;
        iss_valid = 1'b1; iss_rd = 5'd2;
        tick();
        iss_rd = 5'd8;
        tick();
        iss_valid = 1'b0;
        tick();
        check("mr.busy_pre", busy, 32'h0000_0104);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr.WE3", {31'd0, WE3}, 32'd0);
        check("mr.busy", busy, 32'd0);
        check("mr.b_ready", {31'd0, b_ready}, 32'd1);
        a_valid = 1'b0; b_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr.no_stale", {31'd0, WE3}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
